odd_parity_checker: RTL

ODD_PARITY_CHECKER -- requirements
Module: odd_parity_checker

---
 rtl/odd_parity_checker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/odd_parity_checker.sv
// Serial odd-parity frame receiver.
// A frame is DATA_W data bits (MSB first) followed by one parity bit, each
// qualified by bit_valid. The completed word, its parity verdict and a
// saturating error count are presented on registered outputs.
module odd_parity_checker #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count
);

    // Wide enough to hold 0..DATA_W so the count never wraps inside a frame.
    localparam int BCNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [BCNT_W-1:0]   bcnt, bcnt_nx;
    logic [DATA_W-1:0]   shreg, shreg_nx;
    logic                busy_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                out_valid_nx;
    logic                parity_err_nx;
    logic [CNT_W-1:0]    err_count_nx;
    logic                frame_bad;

    // Odd parity: the data ones plus the parity bit must total an odd count.
    assign frame_bad = ~(^shreg ^ bit_in);

    // Next-state and next-output logic for the frame receiver.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case statement can leave it unassigned (no latches).
        state_nx      = state;
        bcnt_nx       = bcnt;
        shreg_nx      = shreg;
        busy_nx       = busy;
        data_nx       = data_out;
        out_valid_nx  = 1'b0;
        parity_err_nx = parity_err;
        err_count_nx  = err_count;

        unique case (state)
            IDLE: begin
                // bit_valid is deliberately ignored here, even alongside start.
                if (start) begin
                    state_nx = DATA;
                    bcnt_nx  = '0;
                    shreg_nx = '0;
                    busy_nx  = 1'b1;
                end
            end

            DATA: begin
                if (bit_valid) begin
                    // Shift in at the LSB; the first bit of the frame ends in the MSB.
                    shreg_nx = DATA_W'({shreg, bit_in});
                    bcnt_nx  = bcnt + BCNT_W'(1);
                    if (bcnt == LAST_BIT) begin
                        state_nx = PARITY;
                    end
                end
            end

            PARITY: begin
                if (bit_valid) begin
                    data_nx       = shreg;
                    parity_err_nx = frame_bad;
                    out_valid_nx  = 1'b1;
                    state_nx      = IDLE;
                    busy_nx       = 1'b0;
                    if (frame_bad && (err_count != {CNT_W{1'b1}})) begin
                        err_count_nx = err_count + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so all
        // of them sample the same pre-edge values, independent of order.
        if (rst) begin
            state      <= IDLE;
            bcnt       <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            bcnt       <= bcnt_nx;
            shreg      <= shreg_nx;
            busy       <= busy_nx;
            data_out   <= data_nx;
            out_valid  <= out_valid_nx;
            parity_err <= parity_err_nx;
            err_count  <= err_count_nx;
        end
    end

endmodule
